prefetch_fetcher: RTL and testbench

Per-core instruction fetcher with a parametrised sequential prefetch buffer, the successor to the single-request fetcher. It serves core FETCH requests from a small in-order buffer of `{address, instruction}` entries that it fills ahead of the PC from program memory. A PC that is not at the buffer head (branch, jump or start) flushes the buffer and restarts prefetch at that PC. The core-facing state encoding and handshake are unchanged from the previous generation.

---
 rtl/prefetch_fetcher_if.sv | 26 ++
 rtl/prefetch_fetcher.sv | 178 +++++++++++++++++
 tb/tb_prefetch_fetcher.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_fetcher_if.sv
// rtl/prefetch_fetcher_if.sv - core and program-memory signal bundle for the prefetch fetcher
interface prefetch_fetcher_if #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
);
  logic [2:0]                       core_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc;
  logic [2:0]                       fetcher_state;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instruction;
  logic                             mem_read_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address;
  logic                             mem_read_ready;
  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data;

  // Fetcher side: requests from memory, serves the core.
  modport master (
    input  core_state, current_pc, mem_read_ready, mem_read_data,
    output fetcher_state, instruction, mem_read_valid, mem_read_address
  );

  // Environment side: core plus program memory.
  modport slave (
    output core_state, current_pc, mem_read_ready, mem_read_data,
    input  fetcher_state, instruction, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/prefetch_fetcher.sv
// rtl/prefetch_fetcher.sv - instruction fetcher with a sequential prefetch buffer
module prefetch_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int PREFETCH_DEPTH        = 4,
  parameter bit PREFETCH_EN           = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  prefetch_fetcher_if.master bus
);
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;
  localparam int PW = $clog2(PREFETCH_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   buf_addr_q [PREFETCH_DEPTH];
  logic [DW-1:0]   buf_data_q [PREFETCH_DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;   // a request is outstanding
  logic [AW-1:0]   addr_q, addr_d;     // address of the outstanding/last request
  logic            stale_q, stale_d;   // outstanding request was orphaned by a flush
  logic [AW-1:0]   next_q, next_d;     // prefetch pointer
  logic [DW-1:0]   instr_q, instr_d;

  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            pop;
  logic            miss;
  logic            fill;
  logic            issue;
  logic            buf_empty;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;

  assign buf_empty = (count_q == '0);
  assign head_addr = buf_addr_q[head_q];
  assign head_data = buf_data_q[head_q];
  assign fill      = valid_q && bus.mem_read_ready;

  assign bus.fetcher_state    = state_q;
  assign bus.instruction      = instr_q;
  assign bus.mem_read_valid   = valid_q;
  assign bus.mem_read_address = addr_q;

  // Core-facing FSM, buffer bookkeeping and request issue.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    stale_d = stale_q;
    next_d  = next_q;
    instr_d = instr_q;
    wr_en   = 1'b0;
    wr_idx  = tail_q;
    pop     = 1'b0;
    miss    = 1'b0;
    issue   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.core_state == CORE_FETCH) begin
          if (!buf_empty && head_addr == bus.current_pc) begin
            instr_d = head_data;
            pop     = 1'b1;
            state_d = FETCHED;
          end else if (buf_empty && valid_q && !stale_q && addr_q == bus.current_pc) begin
            // The wanted word is already in flight; just wait for it.
            state_d = FETCHING;
          end else begin
            miss    = 1'b1;
            state_d = FETCHING;
          end
        end
      end
      FETCHING: begin
        if (!buf_empty) begin
          instr_d = head_data;
          pop     = 1'b1;
          state_d = FETCHED;
        end
      end
      FETCHED: begin
        if (bus.core_state == CORE_DECODE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fill) valid_d = 1'b0;

    if (miss) begin
      // Flush and restart at the PC; an in-flight response is kept only if it is the PC itself.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      next_d  = bus.current_pc;
      if (fill) begin
        stale_d = 1'b0;
        if (!stale_q && addr_q == bus.current_pc) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          tail_d  = PW'(1);
          count_d = CW'(1);
          next_d  = bus.current_pc + AW'(1);
        end
      end else if (valid_q) begin
        stale_d = 1'b1;
      end
    end else begin
      if (pop) head_d = head_q + PW'(1);
      if (fill) begin
        if (stale_q) begin
          stale_d = 1'b0;
        end else begin
          wr_en  = 1'b1;
          wr_idx = tail_q;
          tail_d = tail_q + PW'(1);
        end
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
      issue = !valid_q && (count_q < CW'(PREFETCH_DEPTH)) &&
              (PREFETCH_EN || (state_q == FETCHING && buf_empty));
      if (issue) begin
        valid_d = 1'b1;
        addr_d  = next_q;
        next_d  = next_q + AW'(1);
      end
    end
  end

  // Control and tracking registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      stale_q <= 1'b0;
      next_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      stale_q <= stale_d;
      next_q  <= next_d;
      instr_q <= instr_d;
    end
  end

  // Buffer storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_addr_q[wr_idx] <= addr_q;
      buf_data_q[wr_idx] <= bus.mem_read_data;
    end
  end
endmodule

// File: tb/tb_prefetch_fetcher.sv
// tb/tb_prefetch_fetcher.sv - randomized self-checking bench for prefetch_fetcher
module tb_prefetch_fetcher;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam logic [2:0] C_FETCH = 3'b001, C_DECODE = 3'b010, C_OTHER = 3'b100;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;
  int sel;
  logic [2:0] cs;
  logic [7:0] pc;
  logic rdy;
  logic [15:0] rdata;

  prefetch_fetcher_if #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW)) if0 ();
  prefetch_fetcher_if #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW)) if1 ();

  prefetch_fetcher #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW),
                     .PREFETCH_DEPTH(DEPTH), .PREFETCH_EN(1'b1)) dut0 (
    .clk(clk), .reset(rst_n0), .bus(if0.master));
  prefetch_fetcher #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW),
                     .PREFETCH_DEPTH(DEPTH), .PREFETCH_EN(1'b0)) dut1 (
    .clk(clk), .reset(rst_n1), .bus(if1.master));

  assign if0.core_state     = (sel == 0) ? cs : 3'b000;
  assign if0.current_pc     = (sel == 0) ? pc : 8'h00;
  assign if0.mem_read_ready = (sel == 0) ? rdy : 1'b0;
  assign if0.mem_read_data  = rdata;
  assign if1.core_state     = (sel != 0) ? cs : 3'b000;
  assign if1.current_pc     = (sel != 0) ? pc : 8'h00;
  assign if1.mem_read_ready = (sel != 0) ? rdy : 1'b0;
  assign if1.mem_read_data  = rdata;

  wire        d_valid = (sel != 0) ? if1.mem_read_valid   : if0.mem_read_valid;
  wire [7:0]  d_addr  = (sel != 0) ? if1.mem_read_address : if0.mem_read_address;
  wire [2:0]  d_state = (sel != 0) ? if1.fetcher_state    : if0.fetcher_state;
  wire [15:0] d_instr = (sel != 0) ? if1.instruction      : if0.instruction;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue of {addr, data}, one in-flight request.
  typedef struct packed { logic [7:0] a; logic [15:0] d; } ent_t;
  ent_t m_buf[$];
  ent_t n_buf[$];
  logic [2:0] m_state, n_state;
  logic m_out, n_out, m_stale, n_stale;
  logic [7:0] m_req, n_req, m_next, n_next;
  logic [15:0] m_instr, n_instr;
  bit pe;

  task automatic model_reset(input bit prefetch);
    pe = prefetch;
    m_buf.delete();
    m_state = S_IDLE; m_out = 1'b0; m_stale = 1'b0;
    m_req = 8'h00; m_next = 8'h00; m_instr = 16'h0000;
  endtask

  task automatic model_compute();
    bit fill, miss, issue_ok;
    ent_t e;
    n_buf = m_buf; n_state = m_state; n_out = m_out; n_stale = m_stale;
    n_req = m_req; n_next = m_next; n_instr = m_instr;
    fill = m_out && rdy;
    miss = 1'b0;
    issue_ok = !m_out && (m_buf.size() < DEPTH) &&
               (pe || (m_state == S_FETCHING && m_buf.size() == 0));
    case (m_state)
      S_IDLE: if (cs == C_FETCH) begin
        if (m_buf.size() > 0 && m_buf[0].a == pc) begin
          n_instr = m_buf[0].d; void'(n_buf.pop_front()); n_state = S_FETCHED;
        end else if (m_buf.size() == 0 && m_out && !m_stale && m_req == pc) begin
          n_state = S_FETCHING;
        end else begin
          miss = 1'b1; n_state = S_FETCHING;
        end
      end
      S_FETCHING: if (m_buf.size() > 0) begin
        n_instr = m_buf[0].d; void'(n_buf.pop_front()); n_state = S_FETCHED;
      end
      S_FETCHED: if (cs == C_DECODE) n_state = S_IDLE;
      default: ;
    endcase
    if (fill) n_out = 1'b0;
    if (miss) begin
      n_buf.delete();
      n_next = pc;
      if (fill) begin
        n_stale = 1'b0;
        if (!m_stale && m_req == pc) begin
          e.a = pc; e.d = rdata; n_buf.push_back(e); n_next = pc + 8'd1;
        end
      end else if (m_out) n_stale = 1'b1;
    end else begin
      if (fill) begin
        if (m_stale) n_stale = 1'b0;
        else begin e.a = m_req; e.d = rdata; n_buf.push_back(e); end
      end
      if (issue_ok) begin n_out = 1'b1; n_req = m_next; n_next = m_next + 8'd1; end
    end
  endtask

  // Memory responder and issue tracking.
  int w = 0, cur_lat = 1, lat_min = 1, lat_max = 1;
  logic prev_valid = 1'b0;
  logic [7:0] iss_q[$];
  int iss_cnt = 0;

  task automatic step();
    if (!d_valid) begin
      w = 0;
      rdy = ($urandom_range(0, 3) == 0);
    end else begin
      if (w == 0) cur_lat = $urandom_range(lat_min, lat_max);
      w++;
      rdy = (w >= cur_lat);
    end
    rdata = (rdy && d_valid) ? mem[d_addr] : 16'($urandom);
    model_compute();
    @(posedge clk);
    #1;
    m_buf = n_buf; m_state = n_state; m_out = n_out; m_stale = n_stale;
    m_req = n_req; m_next = n_next; m_instr = n_instr;
    check_eq("state", 32'(d_state), 32'(m_state));
    check_eq("valid", 32'(d_valid), 32'(m_out));
    check_eq("addr", 32'(d_addr), 32'(m_req));
    check_eq("instr", 32'(d_instr), 32'(m_instr));
    if (d_valid && !prev_valid) begin iss_q.push_back(d_addr); iss_cnt++; end
    prev_valid = d_valid;
  endtask

  task automatic fetch(input logic [7:0] p, output int lat);
    cs = C_FETCH; pc = p; lat = 0;
    do begin step(); lat++; end while (m_state != S_FETCHED && lat < 80);
    check_eq("fetch_done", 32'(d_state), 32'(S_FETCHED));
    check_eq("fetch_data", 32'(d_instr), 32'(mem[p]));
  endtask

  task automatic decode_and_idle(input int n);
    cs = C_DECODE; step();
    cs = C_OTHER;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0, k;
    logic [7:0] p;
    logic [7:0] exp_wrap [5];
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    sel = 0; cs = 3'b000; pc = 8'h00; rdy = 1'b0; rdata = 16'h0;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    model_reset(1'b1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(d_valid), 32'd0);
    check_eq("rst_addr", 32'(d_addr), 32'd0);
    check_eq("rst_state", 32'(d_state), 32'(S_IDLE));
    check_eq("rst_instr", 32'(d_instr), 32'd0);
    rst_n0 = 1'b1;
    cs = C_OTHER;
    step();
    check_eq("first_issue_valid", 32'(d_valid), 32'd1);
    check_eq("first_issue_addr", 32'(d_addr), 32'h00);

    // Sequential run, fixed 2-cycle memory latency
    lat_min = 2; lat_max = 2;
    for (int a = 8'h10; a <= 8'h17; a++) begin
      fetch(8'(a), lat);
      if (a != 8'h10) check_eq("seq_hit_lat", 32'(lat), 32'd1);
      if (a != 8'h17) decode_and_idle(8);
    end

    // Branch flush with an outstanding request
    lat_min = 4; lat_max = 4;
    decode_and_idle(0);
    k = 0;
    while (!d_valid && k < 20) begin step(); k++; end
    check_eq("branch_req_pending", 32'(d_valid), 32'd1);
    n0 = iss_q.size();
    fetch(8'h40, lat);
    check_eq("branch_new_issue", 32'(iss_q.size() > n0), 32'd1);
    if (iss_q.size() > n0) check_eq("branch_issue_addr", 32'(iss_q[n0]), 32'h40);
    decode_and_idle(2);

    // Wrap and full with the core stalled in FETCHED
    lat_min = 1; lat_max = 1;
    fetch(8'hFE, lat);
    cs = C_OTHER;
    for (int i = 0; i < 30; i++) step();
    exp_wrap[0] = 8'hFE; exp_wrap[1] = 8'hFF; exp_wrap[2] = 8'h00;
    exp_wrap[3] = 8'h01; exp_wrap[4] = 8'h02;
    check_eq("wrap_issue_count", 32'(iss_q.size() >= 5), 32'd1);
    if (iss_q.size() >= 5)
      for (int i = 0; i < 5; i++)
        check_eq("wrap_issue_seq", 32'(iss_q[iss_q.size() - 5 + i]), 32'(exp_wrap[i]));
    check_eq("full_no_valid", 32'(d_valid), 32'd0);
    decode_and_idle(2);

    // Randomized run with jumps and pending-PC fetches
    lat_min = 1; lat_max = 4;
    p = 8'h80;
    for (int i = 0; i < 40; i++) begin
      if (($urandom_range(0, 4) == 0) && d_valid) p = d_addr;
      else if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      else p = p + 8'd1;
      fetch(p, lat);
      decode_and_idle($urandom_range(0, 5));
    end

    // Reset mid-request
    k = 0;
    while (!d_valid && k < 20) begin step(); k++; end
    check_eq("midrst_pre_valid", 32'(d_valid), 32'd1);
    #2 rst_n0 = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(d_valid), 32'd0);
    check_eq("midrst_state", 32'(d_state), 32'(S_IDLE));
    check_eq("midrst_instr", 32'(d_instr), 32'd0);
    check_eq("midrst_addr", 32'(d_addr), 32'd0);
    model_reset(1'b1);
    rdy = 1'b1; rdata = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_ready_instr", 32'(d_instr), 32'd0);
    check_eq("midrst_ready_valid", 32'(d_valid), 32'd0);
    rdy = 1'b0; w = 0; prev_valid = 1'b0;
    rst_n0 = 1'b1;
    cs = C_OTHER;
    step();
    fetch(8'h00, lat);
    decode_and_idle(1);
    fetch(8'h01, lat);
    decode_and_idle(1);

    // Demand-only instance
    rst_n0 = 1'b0;
    sel = 1;
    model_reset(1'b0);
    w = 0; rdy = 1'b0; prev_valid = 1'b0;
    #1;
    check_eq("dm_rst_valid", 32'(d_valid), 32'd0);
    rst_n1 = 1'b1;
    cs = C_OTHER;
    n0 = iss_cnt;
    for (int i = 0; i < 5; i++) step();
    check_eq("dm_idle_no_issue", 32'(iss_cnt - n0), 32'd0);
    p = 8'h20;
    for (int i = 0; i < 20; i++) begin
      p = ($urandom_range(0, 2) == 0) ? 8'($urandom) : p + 8'd1;
      n0 = iss_cnt;
      fetch(p, lat);
      check_eq("dm_one_issue", 32'(iss_cnt - n0), 32'd1);
      n0 = iss_cnt;
      decode_and_idle($urandom_range(0, 4));
      check_eq("dm_no_extra_issue", 32'(iss_cnt - n0), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
